// File: rtl/frame_length_rr_arbiter.sv
// Packet-granular round-robin arbiter for length-prefixed AXI4-Stream ports.
// Forwards the granted port combinationally and checks payload bytes against the length beat.
module frame_length_rr_arbiter #(
  parameter int NUM_PORTS          = 4,
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int LENGTH_WIDTH       = 16
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NUM_PORTS*C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]                    s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                    s_axis_tready,
  input  logic [NUM_PORTS-1:0]                    s_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]           m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_axis_tlast,
  input  logic [NUM_PORTS-1:0]                    port_enable,
  output logic [NUM_PORTS-1:0]                    grant,
  output logic                                    length_error,
  output logic [15:0]                             error_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int SUM_W = LENGTH_WIDTH + 8;
  localparam logic [SUM_W-1:0] SAT_MAX = {8'd0, {LENGTH_WIDTH{1'b1}}};
  localparam logic [IDX_W:0]   NP      = (IDX_W+1)'(NUM_PORTS);

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [SUM_W-1:0] popcount(input logic [C_AXIS_TKEEP_WIDTH-1:0] keep);
    logic [SUM_W-1:0] n;
    n = '0;
    for (int i = 0; i < C_AXIS_TKEEP_WIDTH; i++) n = n + SUM_W'(keep[i]);
    return n;
  endfunction

  function automatic logic [LENGTH_WIDTH-1:0] sat_add(input logic [LENGTH_WIDTH-1:0] a,
                                                      input logic [SUM_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {8'd0, a} + b;
    return (s > SAT_MAX) ? {LENGTH_WIDTH{1'b1}} : s[LENGTH_WIDTH-1:0];
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t                  state_q, state_d;
  logic [NUM_PORTS-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]        gidx_q, gidx_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    first_beat_q, first_beat_d;
  logic                    length_error_q, length_error_d;
  logic [15:0]             error_count_q, error_count_d;
  logic [LENGTH_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [LENGTH_WIDTH-1:0] exp_len_q, exp_len_d;

  logic [NUM_PORTS-1:0]    req;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic [IDX_W:0]          cand;
  logic                    hs;
  logic [SUM_W-1:0]        beat_bytes;
  logic                    mismatch;
  logic [IDX_W:0]          rr_next;

  assign req = s_axis_tvalid & port_enable;

  // Lowest rotation offset from rr_ptr wins: scan downwards so the last hit is the nearest.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (req[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state_q == BUSY) begin
      m_axis_tdata          = s_axis_tdata[gidx_q*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
      m_axis_tkeep          = s_axis_tkeep[gidx_q*C_AXIS_TKEEP_WIDTH +: C_AXIS_TKEEP_WIDTH];
      m_axis_tvalid         = s_axis_tvalid[gidx_q];
      m_axis_tlast          = s_axis_tlast[gidx_q];
      s_axis_tready[gidx_q] = m_axis_tready;
    end
  end

  assign hs = (state_q == BUSY) && m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    gidx_d         = gidx_q;
    rr_ptr_d       = rr_ptr_q;
    first_beat_d   = first_beat_q;
    length_error_d = 1'b0;
    error_count_d  = error_count_q;
    byte_cnt_d     = byte_cnt_q;
    exp_len_d      = exp_len_q;
    beat_bytes     = popcount(m_axis_tkeep);
    mismatch       = 1'b0;
    rr_next        = {1'b0, gidx_q} + (IDX_W+1)'(1);
    if (rr_next == NP) rr_next = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d      = BUSY;
          grant_d      = NUM_PORTS'(1) << sel_idx;
          gidx_d       = sel_idx;
          byte_cnt_d   = '0;
          first_beat_d = 1'b1;
        end
      end
      BUSY: begin
        if (hs) begin
          if (first_beat_q) begin
            exp_len_d    = m_axis_tdata[LENGTH_WIDTH-1:0];
            first_beat_d = 1'b0;
          end else begin
            byte_cnt_d = sat_add(byte_cnt_q, beat_bytes);
          end
          if (m_axis_tlast) begin
            // tlast on the length beat closes the packet as an empty payload.
            if (first_beat_q) mismatch = (m_axis_tdata[LENGTH_WIDTH-1:0] != '0);
            else              mismatch = (exp_len_q != sat_add(byte_cnt_q, beat_bytes));
            length_error_d = mismatch;
            if (mismatch) error_count_d = sat_inc(error_count_q);
            rr_ptr_d = rr_next[IDX_W-1:0];
            grant_d  = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      grant_q        <= '0;
      gidx_q         <= '0;
      rr_ptr_q       <= '0;
      first_beat_q   <= 1'b0;
      length_error_q <= 1'b0;
      error_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      gidx_q         <= gidx_d;
      rr_ptr_q       <= rr_ptr_d;
      first_beat_q   <= first_beat_d;
      length_error_q <= length_error_d;
      error_count_q  <= error_count_d;
    end
  end

  // Byte accounting is re-initialised on every grant, so it needs no reset.
  always_ff @(posedge clk) begin
    byte_cnt_q <= byte_cnt_d;
    exp_len_q  <= exp_len_d;
  end

  assign grant        = grant_q;
  assign length_error = length_error_q;
  assign error_count  = error_count_q;

endmodule

// File: tb/tb_frame_length_rr_arbiter.sv
// Scoreboard bench for frame_length_rr_arbiter: per-port beat queues drive the inputs,
// an expected-beat queue is filled with hand-derived packets and drained by a monitor.
module tb_frame_length_rr_arbiter;

  logic         clk;
  logic         rstn;
  logic [255:0] s_axis_tdata;
  logic [31:0]  s_axis_tkeep;
  logic [3:0]   s_axis_tvalid;
  logic [3:0]   s_axis_tready;
  logic [3:0]   s_axis_tlast;
  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [3:0]   port_enable;
  logic [3:0]   grant;
  logic         length_error;
  logic [15:0]  error_count;

  frame_length_rr_arbiter #(
    .NUM_PORTS(4), .C_AXIS_TDATA_WIDTH(64), .C_AXIS_TKEEP_WIDTH(8), .LENGTH_WIDTH(16)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .port_enable(port_enable), .grant(grant), .length_error(length_error),
    .error_count(error_count)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [3:0]  grant;
    logic        gap;
    logic        err;
  } exp_t;

  beat_t pq [4][$];
  exp_t  exp_q[$];
  bit    mt_q[$];

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;
  int cyc = 0;
  int last_end = -100;
  int pend = 0;
  bit pend_val = 1'b0;
  logic [3:0] drv_fire;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] mkdata(input int p, input int len, input int b);
    return {16'hD000 + 16'(p), 16'(len), 32'hBEEF0000 | 32'(b)};
  endfunction

  // One packet: a length beat plus nb payload beats, the last one with keep kl.
  task automatic pkt(input int p, input int len, input int nb, input logic [7:0] kl,
                     input bit gap, input bit err, input int n_exp = 99,
                     input bit to_port = 1'b1, input bit to_exp = 1'b1);
    beat_t bt;
    exp_t  e;
    for (int b = 0; b <= nb; b++) begin
      bt.data = (b == 0) ? {16'hF00D, 32'h0, 16'(len)} : mkdata(p, len, b);
      bt.keep = (b == 0 || b != nb) ? 8'hFF : kl;
      bt.last = (b == nb);
      if (to_port) pq[p].push_back(bt);
      if (to_exp && b < n_exp) begin
        e.data  = bt.data;
        e.keep  = bt.keep;
        e.last  = bt.last;
        e.grant = 4'b0001 << p;
        e.gap   = gap && (b == 0);
        e.err   = err;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_drain(input bit ports_too, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) &&
             (!ports_too || (pq[0].size() == 0 && pq[1].size() == 0 &&
                             pq[2].size() == 0 && pq[3].size() == 0));
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d beats still expected, required 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Stimulus driver: advances each port queue on a handshake seen before the edge.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      drv_fire = s_axis_tvalid & s_axis_tready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (drv_fire[p] && pq[p].size() > 0) void'(pq[p].pop_front());
        if (pq[p].size() > 0) begin
          s_axis_tvalid[p]          = 1'b1;
          s_axis_tdata[p*64 +: 64]  = pq[p][0].data;
          s_axis_tkeep[p*8 +: 8]    = pq[p][0].keep;
          s_axis_tlast[p]           = pq[p][0].last;
        end else begin
          s_axis_tvalid[p]          = 1'b0;
          s_axis_tdata[p*64 +: 64]  = '0;
          s_axis_tkeep[p*8 +: 8]    = '0;
          s_axis_tlast[p]           = 1'b0;
        end
      end
      m_axis_tready = (mt_q.size() > 0) ? mt_q.pop_front() : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        pend = 0;
      end else begin
        if (pend == 2) begin
          chk("length_error_pulse", 64'(length_error), 64'(pend_val));
          chk("error_count", 64'(error_count), 64'(exp_errs));
          pend = 1;
        end else if (pend == 1) begin
          chk("length_error_clear", 64'(length_error), 64'd0);
          pend = 0;
        end
        if (grant != 4'b0000) chk("ready_leak", 64'(s_axis_tready & ~grant), 64'd0);
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h, required no beat", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", m_axis_tdata, e.data);
            chk("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
            chk("beat_last", 64'(m_axis_tlast), 64'(e.last));
            chk("beat_grant", 64'(grant), 64'(e.grant));
            if (e.gap) chk("idle_gap", 64'(cyc - last_end), 64'd2);
            if (e.last) begin
              last_end = cyc;
              pend     = 2;
              pend_val = e.err;
              if (e.err) exp_errs++;
            end
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rstn        = 1'b0;
    port_enable = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_length_error", 64'(length_error), 64'd0);
    chk("rst_error_count", 64'(error_count), 64'd0);
    #1 rstn = 1'b1;

    // Single port 0 packet: 14 = 8 + 6 bytes.
    @(posedge clk);
    pkt(0, 14, 2, 8'h3F, 1'b0, 1'b0);
    wait_drain(1'b1, 100);

    // rr_ptr is now 1, so port 1 beats port 0.
    @(posedge clk);
    pkt(1, 10, 2, 8'h03, 1'b0, 1'b0);
    pkt(0, 12, 2, 8'h0F, 1'b1, 1'b0);
    wait_drain(1'b1, 100);

    @(negedge clk);
    #1 rstn = 1'b0;
    exp_errs = 0;
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;

    // All four ports busy: 0,1,2,3,0 with one idle cycle between packets.
    @(posedge clk);
    pkt(0, 16, 2, 8'hFF, 1'b0, 1'b0);
    pkt(1, 16, 2, 8'hFF, 1'b1, 1'b0);
    pkt(2, 16, 2, 8'hFF, 1'b1, 1'b0);
    pkt(3, 16, 2, 8'hFF, 1'b1, 1'b0);
    pkt(0, 16, 2, 8'hFF, 1'b1, 1'b0);
    wait_drain(1'b1, 200);

    // rr_ptr=1: port 2 short payload, port 3 tlast on length 5, port 0 tlast on length 0.
    @(posedge clk);
    pkt(2, 20, 2, 8'hFF, 1'b0, 1'b1);
    pkt(3, 5, 0, 8'hFF, 1'b1, 1'b1);
    pkt(0, 0, 0, 8'hFF, 1'b1, 1'b0);
    wait_drain(1'b1, 200);

    // Backpressure in the middle of a port 1 packet.
    @(posedge clk);
    mt_q = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    pkt(1, 24, 3, 8'hFF, 1'b0, 1'b0);
    wait_drain(1'b1, 100);

    // Port 2 disabled; port 0 disabled during its own packet. rr_ptr=2.
    @(posedge clk);
    port_enable = 4'b1011;
    pkt(3, 8, 1, 8'hFF, 1'b0, 1'b0);
    pkt(0, 8, 1, 8'hFF, 1'b1, 1'b0);
    pkt(0, 4, 1, 8'h0F, 1'b0, 1'b0, 99, 1'b1, 1'b0);
    pkt(1, 16, 2, 8'hFF, 1'b1, 1'b0);
    pkt(2, 8, 1, 8'hFF, 1'b0, 1'b0, 99, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = (grant == 4'b0001);
    end
    chk("port0_granted", 64'(seen), 64'd1);
    #1 port_enable = 4'b1010;
    wait_drain(1'b0, 100);
    repeat (10) @(negedge clk);
    chk("stall_grant", 64'(grant), 64'd0);
    chk("stall_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("p0_pending", 64'(pq[0].size()), 64'd2);
    chk("p2_pending", 64'(pq[2].size()), 64'd2);
    @(posedge clk);
    port_enable = 4'b1111;
    pkt(2, 8, 1, 8'hFF, 1'b0, 1'b0, 99, 1'b0, 1'b1);
    pkt(0, 4, 1, 8'h0F, 1'b1, 1'b0, 99, 1'b0, 1'b1);
    wait_drain(1'b1, 100);

    // Reset while the second beat of a port 1 packet is on the output.
    @(posedge clk);
    pkt(1, 24, 3, 8'hFF, 1'b0, 1'b0, 2);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      seen = m_axis_tvalid && (grant == 4'b0010) && (m_axis_tdata == mkdata(1, 24, 1));
    end
    chk("second_beat_seen", 64'(seen), 64'd1);
    #1 rstn = 1'b0;
    exp_errs = 0;
    @(posedge clk);
    #2 pq[1].delete();
    @(negedge clk);
    chk("midrst_grant", 64'(grant), 64'd0);
    chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_m_tdata", m_axis_tdata, 64'd0);
    chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("midrst_error_count", 64'(error_count), 64'd0);
    chk("midrst_exp_left", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #1 rstn = 1'b1;

    // rr_ptr restarted at 0: port 0 before port 3.
    @(posedge clk);
    pkt(0, 16, 2, 8'hFF, 1'b0, 1'b0);
    pkt(3, 16, 2, 8'hFF, 1'b1, 1'b0);
    wait_drain(1'b1, 100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_length_rr_arbiter.md
Name: frame_length_rr_arbiter

Overview:
- Shares one length-prefixed AXI4-Stream output among NUM_PORTS input streams. Each packet on a port is one frame-length beat followed by the Ethernet frame, ending at tlast.
- Arbitration is round-robin at whole-packet granularity. A grant is held from the length beat until the data tlast.
- Checks that each packet's payload byte count matches its length beat, and reports mismatches.
- Sits between the per-port frame-length merge stages and the shared ATS scheduler/queue input.

Parameters:
- NUM_PORTS, 4: number of input streams (2..16).
- C_AXIS_TDATA_WIDTH, 64: data width in bits. Must be ≥ LENGTH_WIDTH.
- C_AXIS_TKEEP_WIDTH, C_AXIS_TDATA_WIDTH/8: keep width in bytes.
- LENGTH_WIDTH, 16: frame length field width, carried in tdata[LENGTH_WIDTH-1:0] of the length beat.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  NUM_PORTS*C_AXIS_TDATA_WIDTH  input data; port i occupies slice i.
- s_axis_tkeep  in  NUM_PORTS*C_AXIS_TKEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- s_axis_tlast  in  NUM_PORTS  per-port last; asserted only on the final frame beat.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  output data.
- m_axis_tkeep  out  C_AXIS_TKEEP_WIDTH  output keep.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output last.
- port_enable  in  NUM_PORTS  per-port arbitration enable.
- grant  out  NUM_PORTS  one-hot current grant; 0 when idle.
- length_error  out  1  one-cycle pulse on a length mismatch.
- error_count  out  16  saturating count of mismatches.

Behaviour:
- Reset values: state IDLE; grant=0; rr_ptr=0; length_error=0; error_count=0. All s_axis_tready and m_axis_tvalid are 0.
- IDLE state:
  - Outputs deasserted.
  - Request vector is s_axis_tvalid & port_enable.
  - If nonzero, select the first requesting port at or after rr_ptr (wrap modulo NUM_PORTS). Register it into grant, clear byte_cnt, set first_beat=1, go to BUSY next cycle.
  - port_enable is sampled only here.
- BUSY state:
  - Combinational pass-through of the granted port: m_axis_* = granted s_axis_*; granted s_axis_tready = m_axis_tready; all other readies 0.
  - tvalid/tdata stability is the upstream's responsibility; the arbiter adds no bubbles inside a packet.
- Beat accounting, on each m_axis handshake in BUSY:
  - First beat: capture tdata[LENGTH_WIDTH-1:0] into exp_len; clear first_beat.
  - Later beats: byte_cnt += popcount(tkeep), saturating at 2^LENGTH_WIDTH-1.
  - Handshake with tlast: compare exp_len against byte_cnt + popcount(this tkeep), saturated. Then rr_ptr = granted index+1 (wrap), grant=0, state IDLE.
- Packet latency: one idle cycle between a packet's tlast and the next packet's first beat. Arbitration decision to first output beat is 1 cycle.
- A tlast on the length beat itself is a protocol violation. The packet is terminated, compared as a 0-byte payload, and reported per the mismatch rule.
- On mismatch: length_error is high for exactly the cycle after the tlast handshake. error_count increments, saturating at 0xFFFF.
- port_enable deasserted for the granted port during BUSY has no effect until the packet completes.
- Reset mid-packet: immediate return to reset values. The partial packet is truncated without tlast; recovery is the upstream's concern.
- Simultaneous requests: the round-robin order is strict. A port that just finished has the lowest priority next round.

Test Plan:
- Single port 0 sends length=14 then 2 beats (tkeep 0xFF, 0x3F): output matches input, with 1-cycle arbitration latency. grant=0001 during the packet; no length_error; rr_ptr=1 afterwards.
- Ports 0..3 all valid continuously, each with 3-beat packets: grant sequence 0,1,2,3,0. Each packet is contiguous on the output with no interleaving and exactly one idle cycle between packets.
- Port 2 length beat=20 with payload of 16 bytes: length_error pulses once the cycle after tlast; error_count=1.
- Granted port 1: m_axis_tready toggles 1,0,0,1 mid-packet. No beat is lost or duplicated, other ports stay tready=0, and the byte count is still correct.
- port_enable=1011 with all ports valid: port 2 is never granted. Clearing port 0's enable during its own packet lets that packet finish, then port 0 is skipped.
- Assert rstn=0 during the 2nd beat of a packet: the next cycle grant=0, outputs 0, error_count=0. The next packet arbitrates starting from port 0.
